// File: rtl/enc_parity_gen.sv
// Two-stage even-parity Hamming encoder for 8/16/32-bit codewords with valid/ready flow control.
// Define ENC_ERR_INJECT_EN to add the inject_mask port that flips codeword bits for legal modes.
module enc_parity_gen #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          illegal_mod
`ifdef ENC_ERR_INJECT_EN
    ,
    input  logic [MAX_CODEWORD_WIDTH-1:0] inject_mask
`endif
);

    localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int LOW_W            = MAX_PARITY_WIDTH - 1;
    localparam int IN_W             = (MAX_CODEWORD_WIDTH < 26) ? MAX_CODEWORD_WIDTH : 26;

    // Only the non-overall rows are needed; the last parity bit closes even parity instead.
    localparam logic [31:0] H_M0 [3] = '{32'h0000_00B1, 32'h0000_00D2, 32'h0000_00E4};
    localparam logic [31:0] H_M1 [4] = '{32'h0000_AB61, 32'h0000_CDA2, 32'h0000_F1C4, 32'h0000_FE08};
    localparam logic [31:0] H_M2 [5] = '{32'hAAAB_56C1, 32'hCCCD_9B42, 32'hF0F1_E384,
                                         32'hFF01_FC08, 32'hFFFE_0010};

    logic                      ready_en;
    logic                      s1_valid;
    logic                      s2_valid;
    logic [MAX_INFO_WIDTH-1:0] s1_info;
    logic [LOW_W-1:0]          s1_plow;
    logic [1:0]                s1_mode;
    logic                      advance2;

    logic [25:0] din_ext;
    logic [25:0] info_sel;
    logic [31:0] info_pos;
    logic [4:0]  plow_calc;

    logic [25:0] info_full;
    logic [4:0]  plow_full;
    logic        p_top;
    logic        legal;
    logic [31:0] codeword;
    logic [31:0] cw_final;

`ifdef ENC_ERR_INJECT_EN
    logic [MAX_CODEWORD_WIDTH-1:0] s1_mask;
    logic [31:0]                   mask_ext;
`endif

    assign advance2  = !s2_valid || out_ready;
    assign in_ready  = ready_en && (!s1_valid || !s2_valid || out_ready);
    assign out_valid = s2_valid;

    always_comb begin
        din_ext             = '0;
        din_ext[IN_W-1:0]   = data_in[IN_W-1:0];
    end

    // Stage 1: pick the mode's info bits and compute every parity bit except the overall one.
    always_comb begin
        info_sel  = '0;
        info_pos  = '0;
        plow_calc = '0;
        case (work_mod)
            2'b00: begin
                info_sel[3:0] = din_ext[3:0];
                info_pos      = {24'b0, din_ext[3:0], 4'b0};
                for (int i = 0; i < 3; i++) plow_calc[i] = ^(info_pos & H_M0[i]);
            end
            2'b01: begin
                info_sel[10:0] = din_ext[10:0];
                info_pos       = {16'b0, din_ext[10:0], 5'b0};
                for (int i = 0; i < 4; i++) plow_calc[i] = ^(info_pos & H_M1[i]);
            end
            2'b10: begin
                info_sel = din_ext;
                info_pos = {din_ext, 6'b0};
                for (int i = 0; i < 5; i++) plow_calc[i] = ^(info_pos & H_M2[i]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_info  <= '0;
            s1_plow  <= '0;
            s1_mode  <= '0;
`ifdef ENC_ERR_INJECT_EN
            s1_mask  <= '0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_info <= info_sel[MAX_INFO_WIDTH-1:0];
                s1_plow <= plow_calc[LOW_W-1:0];
                s1_mode <= work_mod;
`ifdef ENC_ERR_INJECT_EN
                s1_mask <= inject_mask;
`endif
            end
        end
    end

    // Stage 2: close even parity and assemble {info, parity}; unbuilt or illegal modes give zero.
    always_comb begin
        info_full                     = '0;
        info_full[MAX_INFO_WIDTH-1:0] = s1_info;
        plow_full                     = '0;
        plow_full[LOW_W-1:0]          = s1_plow;
        p_top                         = (^info_full) ^ (^plow_full);
        legal                         = 1'b0;
        codeword                      = '0;
        case (s1_mode)
            2'b00: begin
                legal    = 1'b1;
                codeword = {24'b0, info_full[3:0], p_top, plow_full[2:0]};
            end
            2'b01: begin
                legal    = (MAX_CODEWORD_WIDTH >= 16);
                codeword = {16'b0, info_full[10:0], p_top, plow_full[3:0]};
            end
            2'b10: begin
                legal    = (MAX_CODEWORD_WIDTH >= 32);
                codeword = {info_full, p_top, plow_full};
            end
            default: ;
        endcase
`ifdef ENC_ERR_INJECT_EN
        mask_ext                         = '0;
        mask_ext[MAX_CODEWORD_WIDTH-1:0] = s1_mask;
        cw_final = legal ? (codeword ^ mask_ext) : '0;
`else
        cw_final = legal ? codeword : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid    <= 1'b0;
            data_out    <= '0;
            illegal_mod <= 1'b0;
        end else if (advance2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                data_out    <= cw_final[MAX_CODEWORD_WIDTH-1:0];
                illegal_mod <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_enc_parity_gen.sv
// Scoreboard bench for enc_parity_gen: a 32-bit build and a 16-bit build share one stimulus stream,
// each checked against a syndrome-solving reference model.
module tb_enc_parity_gen;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  work_mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        illegal_mod;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] data_out16;
    logic        illegal_mod16;

    logic [31:0] maskNow;

    exp_t q[$];
    exp_t q16[$];
    int   errors = 0;
    int   checks = 0;
    bit   randReady = 1'b0;

`ifdef ENC_ERR_INJECT_EN
    logic [31:0] inject_mask;
    assign maskNow = inject_mask;
`else
    assign maskNow = '0;
`endif

    enc_parity_gen #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .AMBA_WORD(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .work_mod(work_mod), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .illegal_mod(illegal_mod)
`ifdef ENC_ERR_INJECT_EN
        , .inject_mask(inject_mask)
`endif
    );

    enc_parity_gen #(.MAX_CODEWORD_WIDTH(16), .MAX_INFO_WIDTH(11), .AMBA_WORD(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .data_in(data_in[15:0]), .work_mod(work_mod), .out_valid(out_valid16),
        .out_ready(out_ready), .data_out(data_out16), .illegal_mod(illegal_mod16)
`ifdef ENC_ERR_INJECT_EN
        , .inject_mask(inject_mask[15:0])
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hRow(input int m, input int r);
        case (m)
            0: case (r)
                   0: return 32'hB1;
                   1: return 32'hD2;
                   2: return 32'hE4;
                   default: return 32'hFF;
               endcase
            1: case (r)
                   0: return 32'hAB61;
                   1: return 32'hCDA2;
                   2: return 32'hF1C4;
                   3: return 32'hFE08;
                   default: return 32'hFFFF;
               endcase
            default: case (r)
                   0: return 32'hAAAB56C1;
                   1: return 32'hCCCD9B42;
                   2: return 32'hF0F1E384;
                   3: return 32'hFF01FC08;
                   4: return 32'hFFFE0010;
                   default: return 32'hFFFFFFFF;
               endcase
        endcase
    endfunction

    // Reference: search the parity field for the value that zeroes every H-row syndrome.
    function automatic exp_t model(input logic [1:0] m, input logic [31:0] d, input int maxw,
                                   input logic [31:0] mask);
        exp_t        e;
        int          n, k, p;
        logic [31:0] info, cw, mk;
        bit          found;
        e.data = '0;
        e.ill  = 1'b1;
        if (m == 2'b11) return e;
        n = 8 << m;
        k = (m == 2'b00) ? 4 : (m == 2'b01) ? 11 : 26;
        p = n - k;
        if (n > maxw) return e;
        info  = d & ((32'h1 << k) - 32'h1);
        found = 1'b0;
        cw    = '0;
        for (int c = 0; c < (1 << p) && !found; c++) begin
            cw    = (info << p) | 32'(c);
            found = 1'b1;
            for (int r = 0; r < p; r++)
                if (^(cw & hRow(int'(m), r))) found = 1'b0;
        end
        mk = (maxw < 32) ? (mask & ((32'h1 << maxw) - 32'h1)) : mask;
        e.data = found ? (cw ^ mk) : 32'hDEADBEEF;
        e.ill  = 1'b0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare the presented output against the oldest expectation, then record new accepts.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid) begin
                if (q.size() == 0) checkOutput("spurious_out", 32'(out_valid), 32'h0);
                else begin
                    checkOutput("sb_data", data_out, q[0].data);
                    checkOutput("sb_illegal", 32'(illegal_mod), 32'(q[0].ill));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (out_valid16) begin
                if (q16.size() == 0) checkOutput("spurious_out16", 32'(out_valid16), 32'h0);
                else begin
                    checkOutput("sb16_data", {16'h0, data_out16}, q16[0].data);
                    checkOutput("sb16_illegal", 32'(illegal_mod16), 32'(q16[0].ill));
                    if (out_ready) void'(q16.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(work_mod, data_in, 32, maskNow));
            if (in_valid && in_ready16)
                q16.push_back(model(work_mod, {16'h0, data_in[15:0]}, 16, maskNow));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 right after the edge that took the input.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] d);
        bit acc;
        int n;
        in_valid = 1'b1;
        work_mod = m;
        data_in  = d;
        n   = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        checkOutput("accepted", 32'(acc), 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic directedCheck(input logic [1:0] m, input logic [31:0] d, input logic [31:0] expCw,
                                 input logic expIll, input string name);
        out_ready = 1'b1;
        applyStimulus(m, d);
        @(negedge clk);
        checkOutput({name, "_early"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'h1);
        checkOutput({name, "_data"}, data_out, expCw);
        checkOutput({name, "_ill"}, 32'(expIll), 32'(illegal_mod));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || q16.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_q", q.size(), 32'h0);
        checkOutput("drain_q16", q16.size(), 32'h0);
    endtask

    initial begin
        bit sawLow;
        int stallAcc;
        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        work_mod  = 2'b00;
        out_ready = 1'b1;
`ifdef ENC_ERR_INJECT_EN
        inject_mask = '0;
`endif
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_data_out", data_out, 32'h0);
        checkOutput("reset_illegal", 32'(illegal_mod), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
        #21;
        rst = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_edge", 32'(in_ready), 32'h1);

        directedCheck(2'b00, 32'h0000000B, 32'h000000B1, 1'b0, "m0_xB");
        directedCheck(2'b10, 32'h00000001, 32'h00000063, 1'b0, "m2_x1");
        directedCheck(2'b01, 32'h00000000, 32'h00000000, 1'b0, "m1_x0");
        directedCheck(2'b11, 32'hFFFFFFFF, 32'h00000000, 1'b1, "m3_illegal");

        // Mode 10 is not built into the 16-bit instance.
        applyStimulus(2'b10, 32'h0000FFFF);
        @(negedge clk);
        @(negedge clk);
        checkOutput("w16_m2_valid", 32'(out_valid16), 32'h1);
        checkOutput("w16_m2_data", {16'h0, data_out16}, 32'h0);
        checkOutput("w16_m2_ill", 32'(illegal_mod16), 32'h1);
        @(posedge clk);
        #1;

`ifdef ENC_ERR_INJECT_EN
        inject_mask = 32'h10;
        directedCheck(2'b00, 32'h0000000B, 32'h000000A1, 1'b0, "inj_mask");
        inject_mask = 32'h0;
        directedCheck(2'b00, 32'h0000000B, 32'h000000B1, 1'b0, "inj_zero");
`endif

        // Back-to-back stream with a three-cycle downstream stall in the middle.
        sawLow   = 1'b0;
        stallAcc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus((i % 2 == 1) ? 2'b10 : 2'b00, $urandom);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready) sawLow = 1'b1;
                    if (in_valid && in_ready) stallAcc++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("stall_in_ready_low", 32'(sawLow), 32'h1);
        checkOutput("stall_accepts_le2", 32'(stallAcc <= 2), 32'h1);
        drain();

        // Reset with two transactions in flight.
        applyStimulus(2'b01, 32'h000007FF);
        applyStimulus(2'b10, $urandom);
        checkOutput("inflight_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_data_out", data_out, 32'h0);
        checkOutput("midrst_illegal", 32'(illegal_mod), 32'h0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
        q.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rerst_in_ready_before_edge", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rerst_in_ready_after_edge", 32'(in_ready), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post_reset_quiet", 32'(out_valid), 32'h0);
        directedCheck(2'b10, 32'h00000001, 32'h00000063, 1'b0, "post_reset_m2");

        // Randomized traffic with random backpressure and idle gaps.
        randReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
`ifdef ENC_ERR_INJECT_EN
            inject_mask = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
`endif
            applyStimulus(2'($urandom_range(0, 3)), $urandom);
        end
        randReady = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
